// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS-subset main controller.
// Moore decode of state; pc_en in BEQ_EX follows the ALU zero flag.
module mc_control_fsm #(
  parameter bit ILLEGAL_TRAP = 1'b0,
  parameter int STATE_W      = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               zero,
  output logic [2:0]         alu_control,
  output logic [1:0]         alu_src_a,
  output logic [2:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state_o
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] F_ADDU   = 6'b100001;
  localparam logic [5:0] F_SUBU   = 6'b100011;
  localparam logic [5:0] F_SLL    = 6'b000000;

  // FETCH is listed first so it encodes as zero.
  typedef enum logic [STATE_W-1:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB,
    MEMWR, RTYPE_EX, RTYPE_WB, ORI_EX,
    LUI_EX, IMM_WB, BEQ_EX, JUMP, HALT
  } state_t;

  typedef struct packed {
    logic [2:0] alu_control;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
  } ctrl_t;

  state_t state;
  state_t state_n;
  ctrl_t  c;
  ctrl_t  o;
  logic   is_rtype;
  logic   is_mem;

  assign is_rtype = (op == OP_RTYPE) &&
                    (funct == F_ADDU ||
                     funct == F_SUBU ||
                     funct == F_SLL);
  assign is_mem   = (op == OP_LW) || (op == OP_SW);

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= state_n;
  end

  // Next-state logic and per-state control decode.
  always_comb begin
    state_n = FETCH;
    c       = '0;
    case (state)
      FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = 3'b001;
        c.pc_en     = 1'b1;
        state_n     = DECODE;
      end
      DECODE: begin
        c.alu_src_b = 3'b011;
        unique case (1'b1)
          is_rtype:       state_n = RTYPE_EX;
          is_mem:         state_n = MEMADR;
          (op == OP_ORI): state_n = ORI_EX;
          (op == OP_LUI): state_n = LUI_EX;
          (op == OP_BEQ): state_n = BEQ_EX;
          (op == OP_J):   state_n = JUMP;
          default: begin
            c.illegal_op = 1'b1;
            state_n = ILLEGAL_TRAP ? HALT : FETCH;
          end
        endcase
      end
      RTYPE_EX: begin
        c.alu_src_a = 2'b01;
        unique case (1'b1)
          (funct == F_SUBU): c.alu_control = 3'b001;
          (funct == F_SLL): begin
            c.alu_src_a   = 2'b10;
            c.alu_control = 3'b011;
          end
          default: c.alu_control = 3'b000;
        endcase
        state_n = RTYPE_WB;
      end
      RTYPE_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      ORI_EX: begin
        c.alu_src_a   = 2'b01;
        c.alu_src_b   = 3'b100;
        c.alu_control = 3'b010;
        state_n       = IMM_WB;
      end
      LUI_EX: begin
        c.alu_src_a   = 2'b11;
        c.alu_src_b   = 3'b100;
        c.alu_control = 3'b011;
        state_n       = IMM_WB;
      end
      IMM_WB: c.reg_write = 1'b1;
      MEMADR: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 3'b010;
        state_n = (op == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        c.iord  = 1'b1;
        state_n = MEMWB;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      BEQ_EX: begin
        c.alu_src_a   = 2'b01;
        c.alu_control = 3'b001;
        c.pc_src      = 2'b01;
        c.pc_en       = zero;
      end
      JUMP: begin
        c.pc_src = 2'b10;
        c.pc_en  = 1'b1;
      end
      HALT:    state_n = HALT;
      default: state_n = FETCH;
    endcase
  end

  // Everything is forced quiet while reset is held.
  assign o = reset ? '0 : c;

  assign alu_control = o.alu_control;
  assign alu_src_a   = o.alu_src_a;
  assign alu_src_b   = o.alu_src_b;
  assign pc_src      = o.pc_src;
  assign pc_en       = o.pc_en;
  assign iord        = o.iord;
  assign mem_write   = o.mem_write;
  assign ir_write    = o.ir_write;
  assign reg_write   = o.reg_write;
  assign reg_dst     = o.reg_dst;
  assign mem_to_reg  = o.mem_to_reg;
  assign illegal_op  = o.illegal_op;
  assign state_o     = state;

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: vector table, corner sequences and random
// instruction streams against a per-instruction control model.
module tb_mc_control_fsm;

  typedef logic [17:0] w_t;
  typedef w_t w_q[$];

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    int         cyc;
    int         idx;
    w_t         exp;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;

  logic [2:0] a_aluc, b_aluc;
  logic [1:0] a_sa, b_sa;
  logic [2:0] a_sb, b_sb;
  logic [1:0] a_ps, b_ps;
  logic a_pe, a_io, a_mw, a_ir, a_rw, a_rd, a_mr, a_il;
  logic b_pe, b_io, b_mw, b_ir, b_rw, b_rd, b_mr, b_il;
  logic [3:0] a_st, b_st;
  w_t w0, w1;

  int tests = 0;
  int fails = 0;
  bit have_fetch = 0;
  w_t seen[12];

  mc_control_fsm #(.ILLEGAL_TRAP(1'b0), .STATE_W(4)) dut0 (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .zero(zero), .alu_control(a_aluc), .alu_src_a(a_sa),
    .alu_src_b(a_sb), .pc_src(a_ps), .pc_en(a_pe),
    .iord(a_io), .mem_write(a_mw), .ir_write(a_ir),
    .reg_write(a_rw), .reg_dst(a_rd), .mem_to_reg(a_mr),
    .illegal_op(a_il), .state_o(a_st)
  );

  mc_control_fsm #(.ILLEGAL_TRAP(1'b1), .STATE_W(4)) dut1 (
    .clk(clk), .reset(reset), .op(op), .funct(funct),
    .zero(zero), .alu_control(b_aluc), .alu_src_a(b_sa),
    .alu_src_b(b_sb), .pc_src(b_ps), .pc_en(b_pe),
    .iord(b_io), .mem_write(b_mw), .ir_write(b_ir),
    .reg_write(b_rw), .reg_dst(b_rd), .mem_to_reg(b_mr),
    .illegal_op(b_il), .state_o(b_st)
  );

  assign w0 = {a_aluc, a_sa, a_sb, a_ps, a_pe, a_io,
               a_mw, a_ir, a_rw, a_rd, a_mr, a_il};
  assign w1 = {b_aluc, b_sa, b_sb, b_ps, b_pe, b_io,
               b_mw, b_ir, b_rw, b_rd, b_mr, b_il};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  function automatic w_t mk(
    input int ac, sa, sb, ps, pe, io,
    input int mw, ir, rw, rd, mr, il
  );
    return {3'(ac), 2'(sa), 3'(sb), 2'(ps),
            1'(pe), 1'(io), 1'(mw), 1'(ir),
            1'(rw), 1'(rd), 1'(mr), 1'(il)};
  endfunction

  // Per-instruction micro-program: one control word per cycle.
  function automatic w_q model(
    input logic [5:0] o, input logic [5:0] f, input logic z
  );
    w_q q;
    bit rt;
    bit ok;
    rt = (o == 6'h00) &&
         (f == 6'h21 || f == 6'h23 || f == 6'h00);
    ok = rt || (o inside {6'h23, 6'h2b, 6'h0d,
                          6'h0f, 6'h04, 6'h02});
    q.push_back(mk(0,0,1,0,1,0,0,1,0,0,0,0));
    q.push_back(mk(0,0,3,0,0,0,0,0,0,0,0,int'(!ok)));
    if (rt) begin
      if (f == 6'h21)
        q.push_back(mk(0,1,0,0,0,0,0,0,0,0,0,0));
      else if (f == 6'h23)
        q.push_back(mk(1,1,0,0,0,0,0,0,0,0,0,0));
      else
        q.push_back(mk(3,2,0,0,0,0,0,0,0,0,0,0));
      q.push_back(mk(0,0,0,0,0,0,0,0,1,1,0,0));
    end else if (ok) begin
      case (o)
        6'h23: begin
          q.push_back(mk(0,1,2,0,0,0,0,0,0,0,0,0));
          q.push_back(mk(0,0,0,0,0,1,0,0,0,0,0,0));
          q.push_back(mk(0,0,0,0,0,0,0,0,1,0,1,0));
        end
        6'h2b: begin
          q.push_back(mk(0,1,2,0,0,0,0,0,0,0,0,0));
          q.push_back(mk(0,0,0,0,0,1,1,0,0,0,0,0));
        end
        6'h0d: begin
          q.push_back(mk(2,1,4,0,0,0,0,0,0,0,0,0));
          q.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,0));
        end
        6'h0f: begin
          q.push_back(mk(3,3,4,0,0,0,0,0,0,0,0,0));
          q.push_back(mk(0,0,0,0,0,0,0,0,1,0,0,0));
        end
        6'h04:
          q.push_back(mk(1,1,0,1,int'(z),0,0,0,0,0,0,0));
        default:
          q.push_back(mk(0,0,0,2,1,0,0,0,0,0,0,0));
      endcase
    end
    return q;
  endfunction

  task automatic check(input string nm, input w_t got,
                       input w_t exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b", nm, got, exp);
    end
  endtask

  task automatic check_int(input string nm, input int got,
                           input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_w0", w0, '0);
    check("rst_w1", w1, '0);
    check_int("rst_state", int'(a_st), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    have_fetch = 0;
  endtask

  // Runs one instruction on dut0; cyc = cycles to next FETCH.
  task automatic run_instr(
    input logic [5:0] o, input logic [5:0] f,
    input logic z, input string nm, output int cyc
  );
    w_q q;
    q = model(o, f, z);
    op = o;
    funct = f;
    zero = z;
    cyc = 0;
    for (int k = 0; k < 12; k++) begin
      if (!(k == 0 && have_fetch)) @(negedge clk);
      have_fetch = 0;
      if (k > 0 && w0[4]) begin
        have_fetch = 1;
        cyc = k;
        break;
      end
      seen[k] = w0;
      if (k < q.size())
        check($sformatf("%s c%0d", nm, k), w0, q[k]);
    end
  endtask

  vec_t tbl[13];
  w_q   mq;
  int   cyc;
  int   sel;
  logic [5:0] ro, rf;

  initial begin
    tbl[0]  = '{6'h00, 6'h21, 0, 4, 2,
                mk(0,1,0,0,0,0,0,0,0,0,0,0), "addu_ex"};
    tbl[1]  = '{6'h00, 6'h21, 0, 4, 3,
                mk(0,0,0,0,0,0,0,0,1,1,0,0), "addu_wb"};
    tbl[2]  = '{6'h00, 6'h23, 0, 4, 2,
                mk(1,1,0,0,0,0,0,0,0,0,0,0), "subu_ex"};
    tbl[3]  = '{6'h00, 6'h00, 0, 4, 2,
                mk(3,2,0,0,0,0,0,0,0,0,0,0), "sll_ex"};
    tbl[4]  = '{6'h23, 6'h15, 0, 5, 2,
                mk(0,1,2,0,0,0,0,0,0,0,0,0), "lw_adr"};
    tbl[5]  = '{6'h23, 6'h15, 0, 5, 4,
                mk(0,0,0,0,0,0,0,0,1,0,1,0), "lw_wb"};
    tbl[6]  = '{6'h2b, 6'h07, 0, 4, 3,
                mk(0,0,0,0,0,1,1,0,0,0,0,0), "sw_wr"};
    tbl[7]  = '{6'h0f, 6'h00, 0, 4, 2,
                mk(3,3,4,0,0,0,0,0,0,0,0,0), "lui_ex"};
    tbl[8]  = '{6'h0d, 6'h00, 0, 4, 2,
                mk(2,1,4,0,0,0,0,0,0,0,0,0), "ori_ex"};
    tbl[9]  = '{6'h04, 6'h00, 1, 3, 2,
                mk(1,1,0,1,1,0,0,0,0,0,0,0), "beq_t"};
    tbl[10] = '{6'h04, 6'h00, 0, 3, 2,
                mk(1,1,0,1,0,0,0,0,0,0,0,0), "beq_nt"};
    tbl[11] = '{6'h02, 6'h00, 0, 3, 2,
                mk(0,0,0,2,1,0,0,0,0,0,0,0), "j"};
    tbl[12] = '{6'h3f, 6'h00, 0, 2, 1,
                mk(0,0,3,0,0,0,0,0,0,0,0,1), "ill"};

    do_reset();

    // Reset asserted while sw sits in its memory-write cycle.
    op = 6'h2b;
    funct = 6'h00;
    mq = model(6'h2b, 6'h00, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("swr c%0d", k), w0, mq[k]);
    end
    #1 reset = 1'b1;
    #1;
    check("rst_mid_w", w0, '0);
    check_int("rst_mid_st", int'(a_st), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("post_rst", w0, mk(0,0,1,0,1,0,0,1,0,0,0,0));
    have_fetch = 1;

    foreach (tbl[i]) begin
      run_instr(tbl[i].op, tbl[i].funct, tbl[i].zero,
                tbl[i].name, cyc);
      check_int({tbl[i].name, "_cyc"}, cyc, tbl[i].cyc);
      check(tbl[i].name, seen[tbl[i].idx], tbl[i].exp);
    end

    // Illegal opcode: dut0 resumes, dut1 parks in HALT.
    do_reset();
    op = 6'h3f;
    funct = 6'h00;
    @(negedge clk);
    check("trap_f", w1, mk(0,0,1,0,1,0,0,1,0,0,0,0));
    @(negedge clk);
    check("trap_d", w1, mk(0,0,3,0,0,0,0,0,0,0,0,1));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 0)
        check("notrap_f", w0, mk(0,0,1,0,1,0,0,1,0,0,0,0));
      check($sformatf("halt c%0d", k), w1, '0);
    end
    do_reset();

    for (int n = 0; n < 80; n++) begin
      sel = $urandom_range(0, 9);
      rf = 6'($urandom);
      case (sel)
        0: begin ro = 6'h00; rf = 6'h21; end
        1: begin ro = 6'h00; rf = 6'h23; end
        2: begin ro = 6'h00; rf = 6'h00; end
        3: ro = 6'h23;
        4: ro = 6'h2b;
        5: ro = 6'h0d;
        6: ro = 6'h0f;
        7: ro = 6'h04;
        8: ro = 6'h02;
        default: ro = 6'($urandom);
      endcase
      mq = model(ro, rf, 1'($urandom));
      run_instr(ro, rf, 1'($urandom_range(0, 1)),
                $sformatf("rnd%0d", n), cyc);
      check_int($sformatf("rnd%0d_cyc", n), cyc, mq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multi-cycle main controller for the 32-bit MIPS-subset datapath.
- Drives the ALU's operand selects and 3-bit operation code, then consumes its zero flag to resolve branches.
- Sequences fetch, decode, execute, memory and write-back over 3-5 cycles per instruction.
- Sits between the instruction register (op/funct) and the datapath muxes, register file, memory and PC enable.

Parameters:
- ILLEGAL_TRAP, 0, 0: an unsupported opcode/funct returns to FETCH. 1: the FSM parks in HALT until reset.
- STATE_W, 4, width of the state register and of state_o.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- op  in  6  instruction[31:26] from the instruction register
- funct  in  6  instruction[5:0] from the instruction register
- zero  in  1  ALU zero flag, valid in the cycle its operands are driven
- alu_control  out  3  000 add, 001 sub (A-B), 010 or, 011 shift left (SrcB<<SrcA[4:0])
- alu_src_a  out  2  00 PC, 01 register A, 10 zero-extended shamt, 11 constant 16
- alu_src_b  out  3  000 register B, 001 constant 4, 010 sign-extended imm, 011 sign-extended imm<<2, 100 zero-extended imm
- pc_src  out  2  00 ALU result, 01 ALUOut register, 10 jump target {PC[31:28],imm26,2'b00}
- pc_en  out  1  PC load enable
- iord  out  1  memory address select: 0 PC, 1 ALUOut
- mem_write  out  1  data memory write strobe
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write strobe
- reg_dst  out  1  write register select: 0 rt, 1 rd
- mem_to_reg  out  1  write-back data select: 0 ALUOut, 1 memory data register
- illegal_op  out  1  one-cycle pulse when DECODE detects an unsupported instruction
- state_o  out  STATE_W  current state, for debug

Behaviour:
- Reset (async, active-high): state=FETCH. While reset is asserted, all strobes (pc_en, mem_write, ir_write, reg_write, illegal_op) are 0 and all selects are 0. Reset mid-instruction abandons it with no partial write.
- Outputs are Moore decodes of the state. The only exception is pc_en in BEQ_EX, which equals zero.
- Unlisted outputs are 0 in each state.
- FETCH: iord=0, ir_write=1, alu_src_a=00, alu_src_b=001, alu_control=000, pc_src=00, pc_en=1. Next state DECODE.
- DECODE: alu_src_a=00, alu_src_b=011, alu_control=000 (branch target into ALUOut). Next state by op:
  - 000000 with funct 100001 (addu), 100011 (subu) or 000000 (sll) -> RTYPE_EX
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 001101 (ori) -> ORI_EX
  - 001111 (lui) -> LUI_EX
  - 000100 (beq) -> BEQ_EX
  - 000010 (j) -> JUMP
  - anything else -> illegal_op=1 that cycle, then FETCH (ILLEGAL_TRAP=0) or HALT (ILLEGAL_TRAP=1)
- RTYPE_EX: alu_src_b=000.
  - addu: alu_src_a=01, alu_control=000.
  - subu: alu_src_a=01, alu_control=001.
  - sll: alu_src_a=10, alu_control=011.
  - Next state RTYPE_WB.
- RTYPE_WB: reg_write=1, reg_dst=1, mem_to_reg=0. Next state FETCH.
- ORI_EX: alu_src_a=01, alu_src_b=100, alu_control=010. Next state IMM_WB.
- LUI_EX: alu_src_a=11, alu_src_b=100, alu_control=011 (imm<<16). Next state IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- MEMADR: alu_src_a=01, alu_src_b=010, alu_control=000. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: iord=1. Next state MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR: iord=1, mem_write=1. Next state FETCH.
- BEQ_EX: alu_src_a=01, alu_src_b=000, alu_control=001, pc_src=01, pc_en=zero. Next state FETCH.
- JUMP: pc_src=10, pc_en=1. Next state FETCH.
- HALT: all strobes 0. Stays in HALT until reset.
- Cycle counts, FETCH entry to next FETCH entry: R-type/ori/lui/sw 4, lw 5, beq 3, j 3, illegal 2.
- op/funct are sampled only in DECODE and RTYPE_EX/MEMADR. The instruction register is loaded only in FETCH, so they are stable thereafter.
- Unreachable state encodings go to FETCH on the next clock with all strobes 0.

Test Plan:
- Reset asserted mid-MEMWR, then released -> mem_write drops immediately with the reset; state_o=FETCH; first post-reset cycle has ir_write=1, pc_en=1, alu_src_b=001.
- addu, then subu, then sll -> each 4 cycles; RTYPE_EX alu_control 000/001/011 with alu_src_a 01/01/10; RTYPE_WB reg_write=1, reg_dst=1.
- lw (op 100011), then sw (op 101011) -> lw 5 cycles with MEMWB mem_to_reg=1, reg_write=1; sw 4 cycles with a single mem_write pulse and iord=1.
- beq with zero=1, then beq with zero=0 -> BEQ_EX pc_en=1, pc_src=01 in the first case; pc_en=0 in the second; both take 3 cycles.
- lui, then ori -> LUI_EX alu_src_a=11, alu_src_b=100, alu_control=011; ORI_EX alu_control=010; IMM_WB reg_dst=0.
- op=111111 with ILLEGAL_TRAP=0, then a rerun with ILLEGAL_TRAP=1 -> one illegal_op pulse in DECODE; first run resumes FETCH; second run holds HALT with no strobes for 20 cycles until reset.
